c3lib_ckdiv_chk_ctn: RTL and testbench

C3LIB_CKDIV_CHK_CTN -- requirements
Module: c3lib_ckdiv_chk_ctn

---
 rtl/c3lib_ckdiv_chk_ctn.sv | 195 +++++++++++++++++++
 tb/tb_c3lib_ckdiv_chk_ctn.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c3lib_ckdiv_chk_ctn.sv
// Divided-clock checker: measures clk_div period and high time in clk_in cycles
// and declares lock after LOCK_CNT consecutive periods of DIV_RATIO at 50% duty.
module c3lib_ckdiv_chk_ctn #(
  parameter int unsigned DIV_RATIO = 4,
  parameter int unsigned LOCK_CNT  = 8,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             clk_div,
  input  logic             enable,
  input  logic             err_clr,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt
);

  localparam int unsigned      GOOD_W    = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] PER_EXP   = CNT_W'(DIV_RATIO);
  localparam logic [CNT_W-1:0] HIGH_EXP  = CNT_W'(DIV_RATIO / 2);
  localparam logic [CNT_W-1:0] TMO_CNT   = CNT_W'(2 * DIV_RATIO);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
  localparam logic [GOOD_W-1:0] GOOD_FULL = GOOD_W'(LOCK_CNT);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FIRST   = 3'd1,
    ST_MEASURE = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_ERROR   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic              meta_q, s_q, s_prev_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  hcnt_q, hcnt_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic              locked_q, locked_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [CNT_W-1:0]  high_q, high_d;

  logic rise_c;
  logic good_c;
  logic timeout_c;
  logic capture_c;

  // Two-flop synchronizer plus one history flop for rise detection
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      meta_q   <= 1'b0;
      s_q      <= 1'b0;
      s_prev_q <= 1'b0;
    end else begin
      meta_q   <= clk_div;
      s_q      <= meta_q;
      s_prev_q <= s_q;
    end
  end

  assign rise_c    = s_q & ~s_prev_q;
  assign good_c    = (cnt_q == PER_EXP) && (hcnt_q == HIGH_EXP);
  assign timeout_c = !rise_c && (cnt_q == TMO_CNT);
  assign capture_c = rise_c && ((state_q == ST_MEASURE) ||
                                (state_q == ST_LOCKED)  ||
                                (state_q == ST_ERROR));

  // Period and high-time counters restart at 1 on every synchronized rise
  always_comb begin
    cnt_d  = cnt_q;
    hcnt_d = hcnt_q;
    if (rise_c) begin
      cnt_d  = CNT_W'(1);
      hcnt_d = CNT_W'(1);
    end else begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (s_q && (hcnt_q != CNT_MAX)) begin
        hcnt_d = hcnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      good_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      period_q <= '0;
      high_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      good_q   <= good_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      period_q <= period_d;
      high_q   <= high_d;
    end
  end

  // Lock FSM; a set of err in LOCKED takes priority over a same-cycle err_clr
  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    locked_d = locked_q;
    err_d    = err_q;
    period_d = period_q;
    high_d   = high_q;

    if (capture_c) begin
      period_d = cnt_q;
      high_d   = hcnt_q;
    end

    if (err_clr) begin
      err_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        locked_d = 1'b0;
        good_d   = '0;
        if (enable) begin
          state_d = ST_FIRST;
        end
      end
      ST_FIRST: begin
        locked_d = 1'b0;
        if (rise_c) begin
          state_d = ST_MEASURE;
          good_d  = '0;
        end
      end
      ST_MEASURE: begin
        locked_d = 1'b0;
        if (rise_c) begin
          if (good_c) begin
            if (good_q == GOOD_LAST) begin
              state_d  = ST_LOCKED;
              locked_d = 1'b1;
              good_d   = GOOD_FULL;
            end else begin
              good_d = good_q + GOOD_W'(1);
            end
          end else begin
            good_d = '0;
          end
        end else if (timeout_c) begin
          good_d = '0;
        end
      end
      ST_LOCKED: begin
        locked_d = 1'b1;
        if ((rise_c && !good_c) || timeout_c) begin
          state_d  = ST_ERROR;
          locked_d = 1'b0;
          err_d    = 1'b1;
        end
      end
      ST_ERROR: begin
        locked_d = 1'b0;
        if (err_clr) begin
          state_d = ST_FIRST;
          good_d  = '0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        locked_d = 1'b0;
        good_d   = '0;
      end
    endcase

    // Disable wins over every transition but leaves err untouched
    if (!enable) begin
      state_d  = ST_IDLE;
      locked_d = 1'b0;
      good_d   = '0;
    end
  end

  assign locked     = locked_q;
  assign err        = err_q;
  assign period_cnt = period_q;
  assign high_cnt   = high_q;

endmodule

// File: tb/tb_c3lib_ckdiv_chk_ctn.sv
// Bench for c3lib_ckdiv_chk_ctn: drives clk_div as a list of (period, high)
// cycle counts and checks against a period-level lock/error model.
module tb_c3lib_ckdiv_chk_ctn;

  localparam int unsigned DIV_RATIO = 4;
  localparam int unsigned LOCK_CNT  = 8;
  localparam int unsigned CNT_W     = 8;

  typedef struct {
    int p;
    int h;
    int clr_at;
    int en_at;
  } per_t;

  logic             clk_in = 1'b0;
  logic             rst_n;
  logic             clk_div;
  logic             enable;
  logic             err_clr;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] high_cnt;

  int checks   = 0;
  int failures = 0;

  // Period-level reference model
  bit m_armed, m_locked, m_err, m_in_err;
  int m_good, m_period, m_high, m_cur_p, m_cur_h;

  per_t seq[$];

  always #5 clk_in = ~clk_in;

  c3lib_ckdiv_chk_ctn #(
    .DIV_RATIO(DIV_RATIO),
    .LOCK_CNT (LOCK_CNT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .clk_div   (clk_div),
    .enable    (enable),
    .err_clr   (err_clr),
    .locked    (locked),
    .err       (err),
    .period_cnt(period_cnt),
    .high_cnt  (high_cnt)
  );

  function automatic void model_reset();
    m_armed = 0; m_locked = 0; m_err = 0; m_in_err = 0;
    m_good = 0; m_period = 0; m_high = 0; m_cur_p = 0; m_cur_h = 0;
  endfunction

  // A rise ends the in-flight period; the first rise after arming only starts one
  function automatic void model_rise();
    bit good;
    if (!m_armed) begin
      m_armed = 1;
    end else begin
      m_period = m_cur_p;
      m_high   = m_cur_h;
      good = (m_cur_p == int'(DIV_RATIO)) && (m_cur_h == int'(DIV_RATIO / 2));
      if (m_in_err) begin
        // error state only waits for a clear
      end else if (m_locked) begin
        if (!good) begin
          m_locked = 0; m_err = 1; m_in_err = 1;
        end
      end else if (good) begin
        m_good++;
        if (m_good >= int'(LOCK_CNT)) m_locked = 1;
      end else begin
        m_good = 0;
      end
    end
    m_cur_p = 0;
    m_cur_h = 0;
  endfunction

  function automatic void model_clr();
    m_err = 0;
    if (m_in_err) begin
      m_in_err = 0; m_armed = 0; m_good = 0;
    end
  endfunction

  function automatic void model_en_off();
    m_armed = 0; m_good = 0; m_locked = 0; m_in_err = 0;
  endfunction

  function automatic void push_per(int p, int h, int c, int e);
    per_t s;
    s.p = p; s.h = h; s.clr_at = c; s.en_at = e;
    seq.push_back(s);
  endfunction

  function automatic void push_clean(int n);
    for (int i = 0; i < n; i++) push_per(int'(DIV_RATIO), int'(DIV_RATIO / 2), -1, -1);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; err_clr = 1'b0; clk_div = 1'b0;
    repeat (3) @(negedge clk_in);
    model_reset();
    rst_n  = 1'b1;
    enable = 1'b1;
  endtask

  // One clk_div period (p >= 4); locked sampled 2 and 3 edges after the rise
  task automatic drive_period(input per_t s, output logic lk_pre, output logic lk_post,
                              output bit exp_pre, output bit exp_post);
    exp_pre = m_locked;
    lk_pre  = 1'bx;
    lk_post = 1'bx;
    for (int i = 0; i < s.p; i++) begin
      @(negedge clk_in);
      clk_div = (i < s.h);
      err_clr = (i == s.clr_at);
      enable  = (i != s.en_at);
      if (i == 0) model_rise();
      if (i == 2) lk_pre = locked;
      if (i == 3) lk_post = locked;
    end
    exp_post = m_locked;
    @(posedge clk_in);
    #1;
    m_cur_p += s.p;
    m_cur_h += s.h;
    if (s.clr_at >= 0) model_clr();
    if (s.en_at >= 0) model_en_off();
    err_clr = 1'b0;
    enable  = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; err_clr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      clk_div = 1'($urandom);
    end
    checks++;
    if ({locked, err, period_cnt, high_cnt} !== {1'b0, 1'b0, 8'd0, 8'd0}) begin
      failures++;
      $display("FAIL reset_hold: got locked=%b err=%b period=%0d high=%0d expected all 0",
               locked, err, period_cnt, high_cnt);
    end
    do_reset();
    repeat (4) @(negedge clk_in);
    checks++;
    if ({locked, err, period_cnt, high_cnt} !== {1'b0, 1'b0, 8'd0, 8'd0}) begin
      failures++;
      $display("FAIL reset_release: got locked=%b err=%b period=%0d high=%0d expected all 0",
               locked, err, period_cnt, high_cnt);
    end
  endtask

  task automatic test_clean_lock();
    logic lp, lq;
    bit   ep, eq;
    do_reset();
    seq.delete();
    push_clean(12);
    foreach (seq[k]) begin
      drive_period(seq[k], lp, lq, ep, eq);
      checks++;
      if (lp !== ep || lq !== eq) begin
        failures++;
        $display("FAIL clean_lock latency p%0d: locked +2/+3 got %b/%b expected %b/%b", k, lp, lq, ep, eq);
      end
      checks++;
      if ({locked, err, period_cnt, high_cnt} !== {m_locked, m_err, 8'(m_period), 8'(m_high)}) begin
        failures++;
        $display("FAIL clean_lock p%0d: got l=%b e=%b per=%0d hi=%0d expected l=%b e=%b per=%0d hi=%0d",
                 k, locked, err, period_cnt, high_cnt, m_locked, m_err, m_period, m_high);
      end
    end
    checks++;
    if ({locked, err, period_cnt, high_cnt} !== {1'b1, 1'b0, 8'd4, 8'd2}) begin
      failures++;
      $display("FAIL clean_lock final: got l=%b e=%b per=%0d hi=%0d expected l=1 e=0 per=4 hi=2",
               locked, err, period_cnt, high_cnt);
    end
  endtask

  task automatic test_stuck_low();
    logic lp, lq;
    bit   ep, eq;
    int   det;
    do_reset();
    seq.delete();
    push_clean(9);
    foreach (seq[k]) begin
      drive_period(seq[k], lp, lq, ep, eq);
      checks++;
      if ({locked, err, period_cnt, high_cnt} !== {m_locked, m_err, 8'(m_period), 8'(m_high)}) begin
        failures++;
        $display("FAIL stuck_low prelock p%0d: got l=%b e=%b per=%0d hi=%0d expected l=%b e=%b per=%0d hi=%0d",
                 k, locked, err, period_cnt, high_cnt, m_locked, m_err, m_period, m_high);
      end
    end
    @(negedge clk_in);
    clk_div = 1'b1;
    model_rise();
    det = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk_in);
      clk_div = (i < 2);
      if (i == 8) begin
        checks++;
        if (locked !== 1'b1 || err !== 1'b0) begin
          failures++;
          $display("FAIL stuck_low early: at edge 8 got l=%b e=%b expected l=1 e=0", locked, err);
        end
      end
      if (err === 1'b1) begin
        det = i;
        break;
      end
    end
    checks++;
    if (det < 10 || det > 11) begin
      failures++;
      $display("FAIL stuck_low detect: err seen after %0d edges expected 10..11", det);
    end
    checks++;
    if ({locked, err, period_cnt, high_cnt} !== {1'b0, 1'b1, 8'd4, 8'd2}) begin
      failures++;
      $display("FAIL stuck_low final: got l=%b e=%b per=%0d hi=%0d expected l=0 e=1 per=4 hi=2",
               locked, err, period_cnt, high_cnt);
    end
  endtask

  task automatic test_stretch_clear();
    logic lp, lq;
    bit   ep, eq;
    do_reset();
    seq.delete();
    push_clean(9);
    push_per(5, 2, -1, -1);
    push_clean(1);
    foreach (seq[k]) begin
      drive_period(seq[k], lp, lq, ep, eq);
      checks++;
      if ({locked, err, period_cnt, high_cnt} !== {m_locked, m_err, 8'(m_period), 8'(m_high)}) begin
        failures++;
        $display("FAIL stretch p%0d: got l=%b e=%b per=%0d hi=%0d expected l=%b e=%b per=%0d hi=%0d",
                 k, locked, err, period_cnt, high_cnt, m_locked, m_err, m_period, m_high);
      end
    end
    checks++;
    if ({locked, err, period_cnt, high_cnt} !== {1'b0, 1'b1, 8'd5, 8'd2}) begin
      failures++;
      $display("FAIL stretch capture: got l=%b e=%b per=%0d hi=%0d expected l=0 e=1 per=5 hi=2",
               locked, err, period_cnt, high_cnt);
    end
    seq.delete();
    push_per(4, 2, 3, -1);
    push_clean(9);
    foreach (seq[k]) begin
      drive_period(seq[k], lp, lq, ep, eq);
      checks++;
      if (lp !== ep || lq !== eq) begin
        failures++;
        $display("FAIL stretch relock latency p%0d: locked +2/+3 got %b/%b expected %b/%b", k, lp, lq, ep, eq);
      end
      checks++;
      if ({locked, err, period_cnt, high_cnt} !== {m_locked, m_err, 8'(m_period), 8'(m_high)}) begin
        failures++;
        $display("FAIL stretch relock p%0d: got l=%b e=%b per=%0d hi=%0d expected l=%b e=%b per=%0d hi=%0d",
                 k, locked, err, period_cnt, high_cnt, m_locked, m_err, m_period, m_high);
      end
    end
  endtask

  task automatic test_duty_in_measure();
    logic lp, lq;
    bit   ep, eq;
    do_reset();
    seq.delete();
    push_clean(6);
    push_per(4, 3, -1, -1);
    push_clean(9);
    foreach (seq[k]) begin
      drive_period(seq[k], lp, lq, ep, eq);
      checks++;
      if ({locked, err, period_cnt, high_cnt} !== {m_locked, m_err, 8'(m_period), 8'(m_high)}) begin
        failures++;
        $display("FAIL duty p%0d: got l=%b e=%b per=%0d hi=%0d expected l=%b e=%b per=%0d hi=%0d",
                 k, locked, err, period_cnt, high_cnt, m_locked, m_err, m_period, m_high);
      end
    end
    checks++;
    if (locked !== 1'b1 || err !== 1'b0) begin
      failures++;
      $display("FAIL duty final: got l=%b e=%b expected l=1 e=0", locked, err);
    end
  endtask

  task automatic test_enable_err();
    logic lp, lq;
    bit   ep, eq;
    do_reset();
    seq.delete();
    push_clean(9);
    push_per(4, 2, -1, 3);   // drop enable while locked
    push_clean(9);
    push_per(5, 2, -1, -1);
    push_per(4, 2, -1, 3);   // enter ERROR then drop enable: err kept
    push_clean(3);
    push_per(4, 2, 3, -1);   // err_clr mid-measure
    push_clean(6);
    push_per(6, 3, -1, -1);
    push_per(4, 2, 3, 3);    // clear and disable together
    push_clean(9);
    foreach (seq[k]) begin
      drive_period(seq[k], lp, lq, ep, eq);
      checks++;
      if (lp !== ep || lq !== eq) begin
        failures++;
        $display("FAIL enable_err latency p%0d: locked +2/+3 got %b/%b expected %b/%b", k, lp, lq, ep, eq);
      end
      checks++;
      if ({locked, err, period_cnt, high_cnt} !== {m_locked, m_err, 8'(m_period), 8'(m_high)}) begin
        failures++;
        $display("FAIL enable_err p%0d: got l=%b e=%b per=%0d hi=%0d expected l=%b e=%b per=%0d hi=%0d",
                 k, locked, err, period_cnt, high_cnt, m_locked, m_err, m_period, m_high);
      end
    end
  endtask

  task automatic test_async_reset();
    logic lp, lq;
    bit   ep, eq;
    do_reset();
    seq.delete();
    push_clean(9);
    foreach (seq[k]) drive_period(seq[k], lp, lq, ep, eq);
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("FAIL async prelock: got locked=%b expected 1", locked);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (locked !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL async mid_lock: got l=%b e=%b expected l=0 e=0", locked, err);
    end
    do_reset();
    seq.delete();
    push_clean(9);
    push_per(5, 2, -1, -1);
    push_clean(1);
    foreach (seq[k]) drive_period(seq[k], lp, lq, ep, eq);
    checks++;
    if ({locked, err, period_cnt, high_cnt} !== {m_locked, m_err, 8'(m_period), 8'(m_high)}) begin
      failures++;
      $display("FAIL async preerr: got l=%b e=%b per=%0d hi=%0d expected l=%b e=%b per=%0d hi=%0d",
               locked, err, period_cnt, high_cnt, m_locked, m_err, m_period, m_high);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({locked, err, period_cnt, high_cnt} !== {1'b0, 1'b0, 8'd0, 8'd0}) begin
      failures++;
      $display("FAIL async in_error: got l=%b e=%b per=%0d hi=%0d expected all 0",
               locked, err, period_cnt, high_cnt);
    end
    do_reset();
    seq.delete();
    push_clean(9);
    foreach (seq[k]) begin
      drive_period(seq[k], lp, lq, ep, eq);
      checks++;
      if ({locked, err, period_cnt, high_cnt} !== {m_locked, m_err, 8'(m_period), 8'(m_high)}) begin
        failures++;
        $display("FAIL async relock p%0d: got l=%b e=%b per=%0d hi=%0d expected l=%b e=%b per=%0d hi=%0d",
                 k, locked, err, period_cnt, high_cnt, m_locked, m_err, m_period, m_high);
      end
    end
  endtask

  task automatic test_random();
    logic lp, lq;
    bit   ep, eq;
    do_reset();
    seq.delete();
    for (int k = 0; k < 120; k++) begin
      int p, h, c, e;
      if ($urandom_range(0, 9) < 7) begin
        p = 4; h = 2;
      end else begin
        p = int'($urandom_range(4, 7));
        h = int'($urandom_range(1, p - 1));
      end
      c = ($urandom_range(0, 9) == 0) ? 3 : -1;
      e = ($urandom_range(0, 15) == 0) ? 3 : -1;
      push_per(p, h, c, e);
    end
    foreach (seq[k]) begin
      drive_period(seq[k], lp, lq, ep, eq);
      checks++;
      if (lp !== ep || lq !== eq) begin
        failures++;
        $display("FAIL random latency p%0d: locked +2/+3 got %b/%b expected %b/%b", k, lp, lq, ep, eq);
      end
      checks++;
      if ({locked, err, period_cnt, high_cnt} !== {m_locked, m_err, 8'(m_period), 8'(m_high)}) begin
        failures++;
        $display("FAIL random p%0d (%0d/%0d): got l=%b e=%b per=%0d hi=%0d expected l=%b e=%b per=%0d hi=%0d",
                 k, seq[k].p, seq[k].h, locked, err, period_cnt, high_cnt, m_locked, m_err, m_period, m_high);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    enable  = 1'b0;
    err_clr = 1'b0;
    clk_div = 1'b0;
    model_reset();
    test_reset();
    test_clean_lock();
    test_stuck_low();
    test_stretch_clear();
    test_duty_in_measure();
    test_enable_err();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
